// File: rtl/cpu_pkg.sv
// Shared CPU constants: Cause exception codes and the canonical NOP encoding.
package cpu_pkg;

  localparam logic [4:0]  EXC_INT  = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_ADES = 5'd5;
  localparam logic [4:0]  EXC_RI   = 5'd10;
  localparam logic [4:0]  EXC_OV   = 5'd12;
  localparam logic [31:0] NOP      = 32'h0;

endpackage

// File: rtl/pipe_fd_reg_skid_slot.sv
// One-entry skid slot: keeps the first fetch that arrives during a stall until drained or flushed.
module skid_slot #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_i,
  input  logic              empty_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic              bd_i,
  input  logic [EXC_W-1:0]  exc_i,
  output logic              full_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] instr_o,
  output logic              bd_o,
  output logic [EXC_W-1:0]  exc_o
);

  logic              full_q, full_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              bd_q, bd_d;
  logic [EXC_W-1:0]  exc_q, exc_d;

  // A full slot is never overwritten; the first capture of a stall wins.
  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    if (reset || empty_i) begin
      full_d = 1'b0;
    end else if (capture_i && !full_q) begin
      full_d  = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
      bd_d    = bd_i;
      exc_d   = exc_i;
    end
  end

  always_ff @(posedge clk) begin
    full_q  <= full_d;
    pc_q    <= pc_d;
    instr_q <= instr_d;
    bd_q    <= bd_d;
    exc_q   <= exc_d;
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign bd_o    = bd_q;
  assign exc_o   = exc_q;

endmodule

// File: rtl/pipe_fd_reg.sv
// Fetch/decode pipeline register with stall hold, flush, irq squash, ADEL nullification,
// optional skid slot and a saturating stall counter.
module pipe_fd_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5,
  parameter int N_CLR  = 3,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              irq,
  input  logic [N_CLR-1:0]  clr,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              bd_in,
  input  logic [EXC_W-1:0]  exc_in,
  output logic              out_valid,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic              bd_out,
  output logic [EXC_W-1:0]  exc_out,
  output logic              skid_full,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              bd_q, bd_d;
  logic [EXC_W-1:0]  exc_q, exc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              sk_full;
  logic [PC_W-1:0]   sk_pc;
  logic [DATA_W-1:0] sk_instr;
  logic              sk_bd;
  logic [EXC_W-1:0]  sk_exc;

  logic              clr_any;
  logic              sk_capture, sk_empty;
  logic              src_valid, src_bd;
  logic [PC_W-1:0]   src_pc;
  logic [DATA_W-1:0] src_instr;
  logic [EXC_W-1:0]  src_exc;

  assign clr_any    = |clr;
  assign sk_capture = stall && in_valid && !irq;
  // Leaving a stall always empties the slot: either it drains into the register or a flush drops it.
  assign sk_empty   = irq || (!stall && (clr_any || sk_full));

  generate
    if (SKID != 0) begin : g_skid
      skid_slot #(.DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .capture_i (sk_capture),
        .empty_i   (sk_empty),
        .pc_i      (pc_in),
        .instr_i   (instr_in),
        .bd_i      (bd_in),
        .exc_i     (exc_in),
        .full_o    (sk_full),
        .pc_o      (sk_pc),
        .instr_o   (sk_instr),
        .bd_o      (sk_bd),
        .exc_o     (sk_exc)
      );
    end else begin : g_no_skid
      assign sk_full  = 1'b0;
      assign sk_pc    = '0;
      assign sk_instr = '0;
      assign sk_bd    = 1'b0;
      assign sk_exc   = '0;
    end
  endgenerate

  assign src_valid = sk_full || in_valid;
  assign src_pc    = sk_full ? sk_pc    : pc_in;
  assign src_instr = sk_full ? sk_instr : instr_in;
  assign src_bd    = sk_full ? sk_bd    : bd_in;
  assign src_exc   = sk_full ? sk_exc   : exc_in;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    if (reset || irq || (!stall && (clr_any || !src_valid))) begin
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = '0;
      bd_d    = 1'b0;
      exc_d   = '0;
    end else if (!stall) begin
      valid_d = 1'b1;
      pc_d    = src_pc;
      instr_d = (src_exc == EXC_W'(EXC_ADEL)) ? DATA_W'(NOP) : src_instr;
      bd_d    = src_bd;
      exc_d   = src_exc;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (reset) begin
      cnt_d = '0;
    end else if (!irq && stall && valid_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    pc_q    <= pc_d;
    instr_q <= instr_d;
    bd_q    <= bd_d;
    exc_q   <= exc_d;
    cnt_q   <= cnt_d;
  end

  assign out_valid = valid_q;
  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign bd_out    = bd_q;
  assign exc_out   = exc_q;
  assign skid_full = sk_full;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_fd_reg.sv
// Directed bench for pipe_fd_reg: a skid instance with a 4-bit counter and a no-skid twin on shared inputs.
module tb_pipe_fd_reg;

  logic        clk = 1'b0;
  logic        reset, stall, irq, in_valid, bd_in;
  logic [2:0]  clr;
  logic [31:0] pc_in, instr_in;
  logic [4:0]  exc_in;

  logic        out_valid, bd_out, skid_full;
  logic [31:0] pc_out, instr_out;
  logic [4:0]  exc_out;
  logic [3:0]  stall_cnt;

  logic        ns_valid, ns_bd, ns_skid;
  logic [31:0] ns_pc, ns_instr;
  logic [4:0]  ns_exc;
  logic [3:0]  ns_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_fd_reg #(.SKID(1), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .irq(irq), .clr(clr),
    .in_valid(in_valid), .pc_in(pc_in), .instr_in(instr_in), .bd_in(bd_in), .exc_in(exc_in),
    .out_valid(out_valid), .pc_out(pc_out), .instr_out(instr_out), .bd_out(bd_out),
    .exc_out(exc_out), .skid_full(skid_full), .stall_cnt(stall_cnt)
  );

  pipe_fd_reg #(.SKID(0), .CNT_W(4)) u_noskid (
    .clk(clk), .reset(reset), .stall(stall), .irq(irq), .clr(clr),
    .in_valid(in_valid), .pc_in(pc_in), .instr_in(instr_in), .bd_in(bd_in), .exc_in(exc_in),
    .out_valid(ns_valid), .pc_out(ns_pc), .instr_out(ns_instr), .bd_out(ns_bd),
    .exc_out(ns_exc), .skid_full(ns_skid), .stall_cnt(ns_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic bd, input logic [4:0] exc);
    in_valid = v; pc_in = pc; instr_in = ins; bd_in = bd; exc_in = exc;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic bd, input logic [4:0] exc);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".pc"},    64'(pc_out),    64'(pc));
    chk({tag, ".instr"}, 64'(instr_out), 64'(ins));
    chk({tag, ".bd"},    64'(bd_out),    64'(bd));
    chk({tag, ".exc"},   64'(exc_out),   64'(exc));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; irq = 1'b0; clr = 3'b000;
    drive(1'b1, 32'h1111, 32'hdead_beef, 1'b1, 5'd3);
    step(); step();
    chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("reset.skid", 64'(skid_full), 64'd0);
    chk("reset.cnt",  64'(stall_cnt), 64'd0);
    reset = 1'b0;

    drive(1'b1, 32'h3000, 32'h2000_0001, 1'b0, 5'd0); step();
    chk_out("s3000", 1'b1, 32'h3000, 32'h2000_0001, 1'b0, 5'd0);

    // stall with 0x3004 on the bus; later stall cycles present 0x3008 which must not overwrite
    stall = 1'b1;
    drive(1'b1, 32'h3004, 32'h2000_0002, 1'b0, 5'd0); step();
    chk_out("stall1", 1'b1, 32'h3000, 32'h2000_0001, 1'b0, 5'd0);
    chk("stall1.skid", 64'(skid_full), 64'd1);
    chk("stall1.cnt",  64'(stall_cnt), 64'd1);
    chk("noskid.skid", 64'(ns_skid),   64'd0);
    drive(1'b1, 32'h3008, 32'h2000_0003, 1'b0, 5'd0); step();
    chk("stall2.pc", 64'(pc_out), 64'h3000);
    step();
    chk("stall3.pc",  64'(pc_out),    64'h3000);
    chk("stall3.cnt", 64'(stall_cnt), 64'd3);

    stall = 1'b0; step();
    chk_out("release", 1'b1, 32'h3004, 32'h2000_0002, 1'b0, 5'd0);
    chk("release.skid",  64'(skid_full), 64'd0);
    chk("release.cnt",   64'(stall_cnt), 64'd3);
    chk("noskid.rel.pc", 64'(ns_pc),     64'h3008);

    step();
    chk_out("s3008", 1'b1, 32'h3008, 32'h2000_0003, 1'b0, 5'd0);

    drive(1'b1, 32'h3001, 32'h2000_0004, 1'b1, 5'd4); step();
    chk_out("adel", 1'b1, 32'h3001, 32'h0, 1'b1, 5'd4);

    drive(1'b1, 32'h3005, 32'h2000_0005, 1'b0, 5'd10); step();
    chk_out("ri", 1'b1, 32'h3005, 32'h2000_0005, 1'b0, 5'd10);

    drive(1'b1, 32'h3008, 32'h2000_0003, 1'b0, 5'd0); clr = 3'b010; step();
    chk_out("clr", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);

    clr = 3'b000;
    drive(1'b1, 32'h300c, 32'h2000_0006, 1'b1, 5'd0); step();
    chk_out("s300c", 1'b1, 32'h300c, 32'h2000_0006, 1'b1, 5'd0);

    stall = 1'b1; clr = 3'b001;
    drive(1'b1, 32'h3010, 32'h2000_0007, 1'b0, 5'd0); step();
    chk_out("stallclr", 1'b1, 32'h300c, 32'h2000_0006, 1'b1, 5'd0);
    chk("stallclr.skid", 64'(skid_full), 64'd1);
    chk("stallclr.cnt",  64'(stall_cnt), 64'd4);

    clr = 3'b000; irq = 1'b1; step();
    chk_out("irq", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("irq.skid", 64'(skid_full), 64'd0);
    chk("irq.cnt",  64'(stall_cnt), 64'd4);

    irq = 1'b0; stall = 1'b0; step();
    chk_out("s3010", 1'b1, 32'h3010, 32'h2000_0007, 1'b0, 5'd0);

    // long stall: skid catches an ADEL fetch, counter runs 4 -> 15 and stays there
    stall = 1'b1;
    drive(1'b1, 32'h3014, 32'h2000_0008, 1'b0, 5'd4);
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 10) chk("sat.mid", 64'(stall_cnt), 64'd15);
    end
    chk("sat.cnt",  64'(stall_cnt), 64'd15);
    chk("sat.skid", 64'(skid_full), 64'd1);
    chk("sat.pc",   64'(pc_out),    64'h3010);

    stall = 1'b0;
    drive(1'b1, 32'h3018, 32'h2000_0009, 1'b0, 5'd0); step();
    chk_out("reladel", 1'b1, 32'h3014, 32'h0, 1'b0, 5'd4);
    chk("reladel.skid", 64'(skid_full), 64'd0);

    stall = 1'b1;
    drive(1'b1, 32'h3020, 32'h2000_000a, 1'b0, 5'd0); step();
    chk("cap2.skid", 64'(skid_full), 64'd1);
    stall = 1'b0; clr = 3'b100; step();
    chk_out("relclr", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("relclr.skid", 64'(skid_full), 64'd0);

    clr = 3'b000;
    drive(1'b0, 32'h3024, 32'h2000_000b, 1'b1, 5'd5); step();
    chk_out("invalid", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);

    drive(1'b1, 32'h3024, 32'h2000_000b, 1'b0, 5'd0); step();
    stall = 1'b1; step();
    chk("prerst.skid", 64'(skid_full), 64'd1);
    reset = 1'b1; step();
    chk_out("rststall", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("rststall.skid", 64'(skid_full), 64'd0);
    chk("rststall.cnt",  64'(stall_cnt), 64'd0);
    chk("rststall.nscnt", 64'(ns_cnt),   64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
